// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU, debug) for the single data-memory port, with a per-transfer watchdog.
// Optional macro DMEM_ARB_RR_EN selects round-robin tie-breaking; otherwise the CPU wins every tie.
module dmem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_done,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        o_dbg_state,
  output logic              o_dbg_last_grant
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY_CPU = 2'd1;
  localparam logic [1:0] S_BUSY_DBG = 2'd2;
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  // Handshake: a requester holds x_req (with stable we/addr/wdata) until x_done pulses;
  // x_rdata/x_err are meaningful only while x_done=1 and read as 0 otherwise.
  logic [1:0]      r_state;
  logic            r_last_grant;  // 0 = CPU, 1 = DBG
  logic [WD_W-1:0] r_wdog;
  logic            w_tie_cpu;
  logic            w_pick_cpu;
  logic            w_pick_dbg;
  logic            w_finish;
  logic [31:0]     w_rdata;

`ifdef DMEM_ARB_RR_EN
  assign w_tie_cpu = r_last_grant;
`else
  assign w_tie_cpu = 1'b1;
`endif

  assign w_pick_cpu = cpu_req & (~dbg_req | w_tie_cpu);
  assign w_pick_dbg = dbg_req & ~w_pick_cpu;
  // Ack takes precedence over an expiring watchdog on the same edge.
  assign w_finish   = mem_ack | (r_wdog == WD_LAST);
  assign w_rdata    = (mem_ack & ~mem_we) ? mem_rdata : 32'd0;

  assign o_dbg_state      = r_state;
  assign o_dbg_last_grant = r_last_grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_wdog       <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_done     <= 1'b0;
      cpu_rdata    <= '0;
      cpu_err      <= 1'b0;
      dbg_done     <= 1'b0;
      dbg_rdata    <= '0;
      dbg_err      <= 1'b0;
    end else begin
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      dbg_done  <= 1'b0;
      dbg_rdata <= '0;
      dbg_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_cpu) begin
            mem_req      <= 1'b1;
            mem_we       <= cpu_we;
            mem_addr     <= cpu_addr;
            mem_wdata    <= cpu_wdata;
            r_wdog       <= '0;
            r_last_grant <= 1'b0;
            r_state      <= S_BUSY_CPU;
          end else if (w_pick_dbg) begin
            mem_req      <= 1'b1;
            mem_we       <= dbg_we;
            mem_addr     <= dbg_addr;
            mem_wdata    <= dbg_wdata;
            r_wdog       <= '0;
            r_last_grant <= 1'b1;
            r_state      <= S_BUSY_DBG;
          end
        end
        S_BUSY_CPU, S_BUSY_DBG: begin
          if (w_finish) begin
            mem_req <= 1'b0;
            r_state <= S_IDLE;
            if (r_state == S_BUSY_CPU) begin
              cpu_done  <= 1'b1;
              cpu_err   <= ~mem_ack;
              cpu_rdata <= w_rdata;
            end else begin
              dbg_done  <= 1'b1;
              dbg_err   <= ~mem_ack;
              dbg_rdata <= w_rdata;
            end
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          mem_req <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs driven on the falling edge, outputs checked on the falling edge.
module tb_dmem_arbiter;

  localparam int ADDR_W = 10;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_DBG  = 2'd2;

  logic              CLK = 1'b0;
  logic              RST;
  logic              cpu_req, cpu_we, dbg_req, dbg_we, mem_ack;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr;
  logic [31:0]       cpu_wdata, dbg_wdata, mem_rdata;
  logic              cpu_done, cpu_err, dbg_done, dbg_err;
  logic [31:0]       cpu_rdata, dbg_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        o_dbg_state;
  logic              o_dbg_last_grant;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .o_dbg_state(o_dbg_state), .o_dbg_last_grant(o_dbg_last_grant)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic exp_cpu;

  initial begin
    RST = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    @(negedge CLK);
    step();
    chk("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", {30'd0, cpu_done, dbg_done}, 0);
    chk("rst_err", {30'd0, cpu_err, dbg_err}, 0);
    chk("rst_rdata", cpu_rdata | dbg_rdata, 0);
    chk("rst_last_grant", 32'(o_dbg_last_grant), 1);
    RST = 1'b0;
    step();

    // Ack in IDLE must be ignored
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 0;
    chk("idle_ack_state", 32'(o_dbg_state), 32'(ST_IDLE));
    chk("idle_ack_done", {30'd0, cpu_done, dbg_done}, 0);

    // CPU write, zero-wait memory
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF;
    step();
    chk("w_mem_req", 32'(mem_req), 1);
    chk("w_mem_we", 32'(mem_we), 1);
    chk("w_mem_addr", 32'(mem_addr), 32'h005);
    chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w_state", 32'(o_dbg_state), 32'(ST_CPU));
    chk("w_done_early", 32'(cpu_done), 0);
    mem_ack = 1; mem_rdata = 32'hFFFF_0000;
    step();
    mem_ack = 0;
    chk("w_cpu_done", 32'(cpu_done), 1);
    chk("w_cpu_err", 32'(cpu_err), 0);
    chk("w_cpu_rdata", cpu_rdata, 0);
    chk("w_dbg_done", 32'(dbg_done), 0);
    chk("w_mem_req_clr", 32'(mem_req), 0);
    chk("w_state_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    cpu_req = 0;
    step();
    chk("w_done_pulse", 32'(cpu_done), 0);

    // CPU read, 3 wait cycles, address changes mid-transfer
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010; cpu_wdata = 32'h0BAD_0BAD;
    step();
    chk("r_mem_addr", 32'(mem_addr), 32'h010);
    chk("r_mem_we", 32'(mem_we), 0);
    cpu_addr = 10'h3FF; cpu_wdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_wait_addr", 32'(mem_addr), 32'h010);
      chk("r_wait_done", 32'(cpu_done), 0);
      chk("r_wait_req", 32'(mem_req), 1);
    end
    mem_ack = 1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 0; mem_rdata = 32'h9999_9999;
    chk("r_cpu_done", 32'(cpu_done), 1);
    chk("r_cpu_rdata", cpu_rdata, 32'h12345678);
    chk("r_cpu_err", 32'(cpu_err), 0);
    cpu_req = 0;
    step();
    chk("r_rdata_clr", cpu_rdata, 0);

    // Both requesters held for 4 transfers from a fresh reset
    RST = 1;
    step();
    RST = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h001;
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h2AA; dbg_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_cpu = (i % 2 == 0);
`else
      exp_cpu = 1'b1;
`endif
      step();
      chk("tie_state", 32'(o_dbg_state), exp_cpu ? 32'(ST_CPU) : 32'(ST_DBG));
      chk("tie_addr", 32'(mem_addr), exp_cpu ? 32'h001 : 32'h2AA);
      chk("tie_we", 32'(mem_we), exp_cpu ? 0 : 1);
      mem_ack = 1; mem_rdata = 32'h1000_0000 + 32'(i);
      step();
      mem_ack = 0;
      chk("tie_cpu_done", 32'(cpu_done), 32'(exp_cpu));
      chk("tie_dbg_done", 32'(dbg_done), 32'(!exp_cpu));
      chk("tie_rdata", exp_cpu ? cpu_rdata : dbg_rdata, exp_cpu ? 32'h1000_0000 + 32'(i) : 0);
    end
    cpu_req = 0; dbg_req = 0;
    step();

    // Debug read that never gets an ack: timeout after 15 cycles of mem_req
    dbg_req = 1; dbg_we = 0; dbg_addr = 10'h0C3; mem_rdata = 32'h7777_7777;
    step();
    chk("to_mem_req", 32'(mem_req), 1);
    for (int i = 0; i < 14; i++) begin
      step();
      chk("to_wait_done", 32'(dbg_done), 0);
      chk("to_wait_req", 32'(mem_req), 1);
    end
    step();
    chk("to_dbg_done", 32'(dbg_done), 1);
    chk("to_dbg_err", 32'(dbg_err), 1);
    chk("to_dbg_rdata", dbg_rdata, 0);
    chk("to_cpu_done", 32'(cpu_done), 0);
    chk("to_mem_req_clr", 32'(mem_req), 0);
    dbg_req = 0;
    step();
    chk("to_err_clr", 32'(dbg_err), 0);
    chk("to_idle_req", 32'(mem_req), 0);

    // CPU read acked on the very edge the watchdog expires
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h123;
    step();
    for (int i = 0; i < 14; i++) step();
    chk("ta_pre_done", 32'(cpu_done), 0);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 0;
    chk("ta_cpu_done", 32'(cpu_done), 1);
    chk("ta_cpu_err", 32'(cpu_err), 0);
    chk("ta_cpu_rdata", cpu_rdata, 32'hCAFEF00D);
    cpu_req = 0;
    step();

    // Reset in the 2nd BUSY cycle, then a tie after reset goes to the CPU
    cpu_req = 1; dbg_req = 1;
    step();
`ifdef DMEM_ARB_RR_EN
    chk("rb_grant", 32'(o_dbg_state), 32'(ST_DBG));
`else
    chk("rb_grant", 32'(o_dbg_state), 32'(ST_CPU));
`endif
    step();
    RST = 1;
    step();
    chk("rb_mem_req", 32'(mem_req), 0);
    chk("rb_state", 32'(o_dbg_state), 32'(ST_IDLE));
    chk("rb_done", {30'd0, cpu_done, dbg_done}, 0);
    RST = 0;
    step();
    chk("rb_tie_cpu", 32'(o_dbg_state), 32'(ST_CPU));
    chk("rb_no_done", {30'd0, cpu_done, dbg_done}, 0);
    mem_ack = 1; mem_rdata = 32'h0000_BEEF;
    step();
    mem_ack = 0;
    chk("rb_cpu_done", 32'(cpu_done), 1);
    chk("rb_dbg_done", 32'(dbg_done), 0);
    cpu_req = 0; dbg_req = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the CPU load/store path and the debug/loader port. Each requester issues a word read or write with a req/done handshake. The arbiter latches the winning request, drives a registered request onto the memory port, and waits for the memory acknowledge. A timeout watchdog guarantees completion. It sits between the execute stage / debug unit and the data memory.

## Interface
- ADDR_W, 10, word-address width of the memory port
- TIMEOUT, 15, maximum BUSY cycles without `mem_ack` before abort (≥2)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU request; held until `cpu_done`
- cpu_we  in  1  1 = write (SW), 0 = read (LW)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data; valid while `cpu_done`=1
- cpu_err  out  1  timeout flag; valid while `cpu_done`=1
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_done, dbg_rdata, dbg_err: same directions, widths and meanings as the cpu_* ports, for the debug requester
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  32  registered write data
- mem_ack  in  1  memory completed the transfer this cycle
- mem_rdata  in  32  read data; valid with `mem_ack`

## Operation
- FSM states: IDLE, BUSY_CPU, BUSY_DBG.
- IDLE:
  - No request: remain in IDLE.
  - One requester active: grant it.
  - Both active: arbitrate (see Configuration).
  - On grant: latch we/addr/wdata into the mem_* registers, set `mem_req`=1, clear the watchdog, set `last_grant` to the winner, and enter BUSY_x.
- BUSY_x:
  - `mem_ack`=1: go to IDLE, clear `mem_req`, and pulse x_done for 1 cycle. For a read, x_rdata=`mem_rdata` captured at ack; for a write, x_rdata=0. x_err=0.
  - No ack: the watchdog increments. When it equals TIMEOUT-1 with no ack, go to IDLE, clear `mem_req`, pulse x_done, set x_err=1 and x_rdata=0.
- The latched request is immutable while BUSY. Changes on x_req/addr/wdata are ignored, and deassertion of x_req mid-transfer does not abort.
- `mem_ack` in IDLE is ignored.
- x_done is never asserted for the requester that is not granted.
- x_rdata and x_err are held at 0 except in the done cycle.

## Timing
- Reset values: state=IDLE; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; all *_done, *_rdata, *_err=0; watchdog=0; last_grant=DBG, so the CPU wins the first tie.
- Request sampled in IDLE at edge N: `mem_req`=1 from cycle N+1.
- `mem_ack` sampled at edge M: x_done=1 during cycle M+1, and state=IDLE in that same cycle.
- Minimum latency is 2 cycles from req to done, with a zero-wait memory (ack in the first BUSY cycle).
- Back-to-back: the requester must drop req in its done cycle or it is re-arbitrated at that edge. Each transfer costs at least 2 cycles.
- Timeout: done/err asserted TIMEOUT cycles after `mem_req` rises.
- Ack on the same edge the watchdog expires: ack wins, and err=0.
- RST during BUSY: immediate return to IDLE with `mem_req`=0, no done pulse, and the memory transfer is abandoned.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On a tie the requester ≠ `last_grant` wins.
- `DMEM_ARB_RR_EN` undefined: fixed priority; CPU always wins ties. `last_grant` is still maintained but not used.

## Test plan
- Single CPU write, addr=0x005, wdata=0xDEADBEEF, ack on 1st BUSY cycle -> mem_req/we/addr/wdata match from cycle N+1; cpu_done pulse at N+2; cpu_err=0; dbg_done stays 0.
- CPU read, addr=0x010, ack after 3 wait cycles with mem_rdata=0x12345678 -> cpu_done with cpu_rdata=0x12345678 exactly one cycle after ack; mem_addr stable throughout even if cpu_addr changes.
- Both req held continuously for 4 transfers -> RR_EN defined: grant order CPU, DBG, CPU, DBG. RR_EN undefined: CPU for every transfer while cpu_req is held.
- No ack, TIMEOUT=15 -> dbg_done=1 and dbg_err=1 exactly 15 cycles after mem_req rises; mem_req=0 next. Ack coinciding with the final watchdog cycle gives err=0.
- RST asserted in the 2nd BUSY cycle -> next cycle: mem_req=0, state IDLE, no done pulses. After RST deasserts, a tie is granted to the CPU.
